// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings, instruction width and default boot PC.
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push is accepted on full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding req/ack memory request, prefetch FIFO of {pc, instr}, redirect flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = INSTR_W,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int          FW       = ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] redir_pc, pc_inc;
  logic [CW-1:0]     count, cnt_after;
  logic [FW-1:0]     head;
  logic              push, pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pop        = instr_valid & instr_ready & ~redirect_valid;
    redir_pc   = redirect_pc & ~ADDR_W'(3);
    pc_inc     = fetch_pc_q + ADDR_W'(4);
    cnt_after  = pop ? count : count + 1'b1;
    if (redirect_valid) fetch_pc_d = redir_pc;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          state_d    = WAIT;
          mem_addr_d = redir_pc;
        end else if (count < FULL_CNT) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // An ack landing with the redirect is stale; otherwise drain it in DISCARD.
          if (mem_ack) mem_addr_d = redir_pc;
          else         state_d    = DISCARD;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          if (cnt_after < FULL_CNT) mem_addr_d = pc_inc;
          else                      state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d    = WAIT;
          mem_addr_d = redirect_valid ? redir_pc : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({fetch_pc_q, mem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head[DATA_W-1:0]  : '0;
  assign instr_pc    = instr_valid ? head[FW-1:DATA_W] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model with queues, directed scenarios plus random traffic.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outstanding request (req, addr, discard-on-return), next fetch pc, and the buffered words.
  bit          m_req  = 1'b0;
  logic [31:0] m_addr = '0;
  bit          m_disc = 1'b0;
  logic [31:0] m_pc   = '0;
  logic [31:0] q_pc[$];
  logic [31:0] q_dat[$];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_addr", mem_addr, m_addr);
    chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
    chk("instr_pc", instr_pc, (q_pc.size() != 0) ? q_pc[0] : 32'h0);
    chk("instr_data", instr_data, (q_dat.size() != 0) ? q_dat[0] : 32'h0);
  endtask

  task automatic model_update(input bit rst_n, input bit redir, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] rdata, input bit rdy);
    int pre;
    bit do_pop;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_req = 0; m_addr = 32'h0; m_disc = 0; m_pc = 32'h0;
      q_pc.delete(); q_dat.delete();
      return;
    end
    pre = q_pc.size();
    if (redir) begin
      tgt = {rpc[31:2], 2'b00};
      q_pc.delete(); q_dat.delete();
      if (!m_req || ack) begin
        m_req = 1; m_addr = tgt; m_disc = 0;
      end else begin
        m_disc = 1;
      end
      m_pc = tgt;
      return;
    end
    do_pop = (pre != 0) && rdy;
    if (do_pop) begin
      void'(q_pc.pop_front()); void'(q_dat.pop_front());
    end
    if (!m_req) begin
      if (pre < DEPTH) begin
        m_req = 1; m_addr = m_pc;
      end
    end else if (ack) begin
      if (m_disc) begin
        m_disc = 0; m_addr = m_pc;
      end else begin
        q_pc.push_back(m_pc); q_dat.push_back(rdata);
        m_pc = m_pc + 32'd4;
        if (q_pc.size() < DEPTH) m_addr = m_pc;
        else m_req = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst_n, input bit redir, input logic [31:0] rpc,
                      input bit ack, input bit rdy);
    logic [31:0] rd;
    rd = mem_word(m_addr);
    reset = rst_n; redirect_valid = redir; redirect_pc = rpc;
    mem_ack = ack; mem_rdata = rd; instr_ready = rdy;
    model_update(rst_n, redir, rpc, ack, rd, rdy);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    @(negedge clk);
    compare_model();
    step(0, 0, 0, 0, 0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // Zero-wait memory, consumer always ready.
    step(1, 0, 0, 0, 1);
    chk("zw_first_req", 32'(mem_req), 32'h1);
    chk("zw_first_addr", mem_addr, 32'h0);
    step(1, 0, 0, 1, 1);
    chk("zw_valid", 32'(instr_valid), 32'h1);
    chk("zw_pc0", instr_pc, 32'h0);
    chk("zw_data0", instr_data, mem_word(32'h0));
    chk("zw_addr4", mem_addr, 32'h4);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1);
    chk("zw_addr_run", mem_addr, 32'h1C);

    // Backpressure: four acks fill the FIFO, then fetch idles.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
    chk("bp_idle_req", 32'(mem_req), 32'h0);
    chk("bp_head_pc", instr_pc, 32'h0);
    chk("bp_valid", 32'(instr_valid), 32'h1);
    step(1, 0, 0, 1, 0);
    chk("bp_ack_ignored", 32'(mem_req), 32'h0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("bp_refetch_req", 32'(mem_req), 32'h1);
    chk("bp_refetch_addr", mem_addr, 32'h10);
    chk("bp_head_after_pop", instr_pc, 32'h4);

    // Redirect while the request to 0x8 is pending for three cycles.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h100, 0, 0);
    chk("rd_flush_valid", 32'(instr_valid), 32'h0);
    chk("rd_stale_addr", mem_addr, 32'h8);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("rd_new_addr", mem_addr, 32'h100);
    chk("rd_no_stale", 32'(instr_valid), 32'h0);
    step(1, 0, 0, 1, 0);
    chk("rd_first_pc", instr_pc, 32'h100);

    // Redirect with ack, then a double redirect through DISCARD, then an unaligned target.
    step(1, 1, 32'h180, 1, 1);
    chk("rda_addr", mem_addr, 32'h180);
    chk("rda_valid", 32'(instr_valid), 32'h0);
    step(1, 1, 32'h1C0, 0, 1);
    step(1, 1, 32'h200, 0, 1);
    step(1, 0, 0, 1, 1);
    chk("rd2_addr", mem_addr, 32'h200);
    step(1, 0, 0, 1, 0);
    chk("rd2_pc", instr_pc, 32'h200);
    step(1, 1, 32'h103, 1, 0);
    chk("unaligned_addr", mem_addr, 32'h100);

    // Reset mid-WAIT with a late ack.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rmw_req", 32'(mem_req), 32'h0);
    chk("rmw_valid", 32'(instr_valid), 32'h0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("rmw_restart_addr", mem_addr, 32'h0);
    chk("rmw_late_ignored", 32'(instr_valid), 32'h0);

    // PC wrap.
    step(1, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    chk("wrap_pc_zero", instr_pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, ak, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 99) < 5);
      rp  = $urandom;
      ak  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 65);
      step(r, rd, rp, ak, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the single-cycle MIPS datapath.
- Generates word-aligned fetch addresses and issues them to an instruction memory that has variable latency, using a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the decode/execute side with valid/ready.
- On a taken branch or jump (redirect), flushes the FIFO and restarts fetch at the new target.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- redirect_valid  in  1  taken branch or jump this cycle.
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] ignored and forced to 0.
- mem_req  out  1  fetch request, held until ack.
- mem_addr  out  ADDR_W  fetch address, stable while mem_req=1.
- mem_ack  in  1  single-cycle; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  fetched word.
- instr_valid  out  1  FIFO head valid.
- instr_data  out  DATA_W  head instruction word.
- instr_pc  out  ADDR_W  PC of the head instruction.
- instr_ready  in  1  consumer accepts head; a pop occurs when instr_valid & instr_ready.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0.
  - instr_data and instr_pc read 0 whenever instr_valid=0 (gated outputs).
  - Reset overrides every other input, including during an outstanding request; a late mem_ack after reset is ignored.
- At most one request is outstanding. All of state, mem_req and mem_addr are registered.
- FSM states and transitions:
  - IDLE: no outstanding request, mem_req=0. If count<FIFO_DEPTH and no redirect, go to WAIT with mem_addr=fetch_pc.
  - WAIT: mem_req=1. mem_ack may arrive in any cycle, including the first cycle mem_req is high. On ack without redirect:
    - push {fetch_pc, mem_rdata}; fetch_pc += 4 (wraps modulo 2^ADDR_W).
    - If the post-push/post-pop count is below FIFO_DEPTH, stay in WAIT with the new mem_addr next cycle (back-to-back fetch, 1 word/cycle peak). Otherwise go to IDLE.
  - DISCARD: mem_req=1 with the stale address until ack. The acked data is dropped. Then go to WAIT with mem_addr=fetch_pc.
- Redirect has priority over push and pop:
  - Flush: count becomes 0 next cycle, and no pop is counted in that cycle.
  - fetch_pc=redirect_pc.
  - From IDLE: go to WAIT at redirect_pc.
  - From WAIT with mem_ack in the same cycle: drop the data; go to WAIT at redirect_pc.
  - From WAIT without mem_ack: go to DISCARD.
  - In DISCARD: update the target; stay in DISCARD unless mem_ack arrives, then go to WAIT at the latest target.
- Overflow is impossible by construction: a request is only issued when count<FIFO_DEPTH, and count cannot grow before that ack.
- Simultaneous push and pop when the FIFO is full is legal; count is unchanged.
- Pop on empty is ignored.
- No combinational path from instr_ready or redirect_valid to mem_req or mem_addr.

Decomposition:
- Shared include header (alongside the existing CPU includes):
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2).
  - Instruction word width constant.
  - Default RESET_PC.
- One natural sub-module: sync_fifo (parameterised width/depth, synchronous active-low reset, flush input, push/pop, count output, simultaneous push/pop on full). Holds the {pc, instr} pairs, 64 bits wide.
- FSM and PC logic stay in instr_fetch_unit.

Test Plan:
- Zero-wait memory with instr_ready=1 held: after reset release, mem_addr runs 0x0, 0x4, 0x8, … one per cycle. instr_pc/instr_data match the memory model in order, with first instr_valid one cycle after the first ack.
- Backpressure with instr_ready=0: exactly 4 acks are accepted, then mem_req=0 in IDLE and instr_valid stays 1 with instr_pc=0x0. After one pop, a single new request is issued at addr 0x10.
- Redirect to 0x0000_0100 while a request to 0x8 waits 3 cycles:
  - Next cycle FIFO is empty and state is DISCARD.
  - The 0x8 data is never presented.
  - After its ack, mem_addr=0x100 and the first instr_pc out is 0x100.
- Redirect coincident with mem_ack, plus a second redirect to 0x200 during DISCARD: no stale word is output, and fetch resumes at 0x200. Separately, redirect_pc=0x103 yields fetch at 0x100.
- Reset mid-WAIT with memory acking 2 cycles later: the outputs return to their reset values, the late ack is ignored, and fetch restarts at RESET_PC. Also cover fetch_pc wrapping from 0xFFFF_FFFC to 0x0.
